// File: rtl/pipeline_hazard_ctl_pkg.sv
// Purpose: shared types and constants for the pipeline hazard sequencer.
// Latency: n/a (types and a combinational helper only).
// Backpressure: n/a.
package pipeline_hazard_ctl_pkg;

    localparam int REG_ADDR_WIDTH = 5;

    typedef enum logic [1:0] {
        HZ_RUN      = 2'd0,
        HZ_LOAD_USE = 2'd1,
        HZ_FLUSH    = 2'd2
    } hazard_state_t;

    // A load in EX feeding a source that ID actually reads; x0 is hardwired zero and never hazards.
    function automatic logic load_use_hit(
        input logic                      ex_mem_read,
        input logic [REG_ADDR_WIDTH-1:0] ex_rd,
        input logic                      uses_rs1,
        input logic [REG_ADDR_WIDTH-1:0] rs1,
        input logic                      uses_rs2,
        input logic [REG_ADDR_WIDTH-1:0] rs2
    );
        return ex_mem_read && (ex_rd != '0) &&
               ((uses_rs1 && (rs1 == ex_rd)) || (uses_rs2 && (rs2 == ex_rd)));
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctl_perf_counter_sat.sv
// Purpose: enable-driven event counter that sticks at all-ones instead of wrapping.
// Latency: count visible one cycle after the enabled edge.
// Backpressure: none; an increment at saturation is silently dropped.
module perf_counter_sat #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Advance only when requested and not already pinned at the ceiling.
    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Counter register, cleared by the asynchronous reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipeline_hazard_ctl.sv
// Purpose: arbitrates memory stall, EX redirect and ID load-use; sequences stall/flush windows.
// Latency: stage controls are Mealy (same cycle); counters and timeout update on the next edge.
// Backpressure: want_stall freezes every stage and all sequencing state until released.
module pipeline_hazard_ctl
    import pipeline_hazard_ctl_pkg::*;
#(
    parameter int LOAD_USE_CYCLES = 1,
    parameter int FLUSH_CYCLES    = 0,
    parameter int MEM_TIMEOUT     = 255,
    parameter int COUNTER_WIDTH   = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      want_stall,
    input  logic                      redirect,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
    input  logic                      id_uses_rs1,
    input  logic                      id_uses_rs2,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
    input  logic                      ex_mem_read,
    output logic                      pc_write_enable,
    output logic                      if_id_write_enable,
    output logic                      if_id_flush,
    output logic                      id_ex_bubble,
    output logic                      no_stall,
    output logic [COUNTER_WIDTH-1:0]  stall_count,
    output logic [COUNTER_WIDTH-1:0]  flush_count,
    output logic                      mem_timeout
);

    // Reload values: the entry cycle itself is the first bubble/flush, so the counter covers the rest.
    localparam logic [3:0]  LU_RELOAD   = 4'((LOAD_USE_CYCLES > 1) ? LOAD_USE_CYCLES - 2 : 0);
    localparam logic [3:0]  FL_RELOAD   = 4'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);
    localparam logic [15:0] TIMEOUT_LIM = 16'(MEM_TIMEOUT);

    hazard_state_t state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [15:0]   wait_q, wait_d;
    logic          mem_timeout_q, mem_timeout_d;

    logic pc_we, ifid_we, ifid_fl, bubble, adv, redirect_acc, lu;

    assign lu = load_use_hit(ex_mem_read, ex_rd, id_uses_rs1, id_rs1, id_uses_rs2, id_rs2);

    // Hazard arbitration and window sequencing: want_stall > redirect > load-use.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pc_we        = 1'b1;
        ifid_we      = 1'b1;
        ifid_fl      = 1'b0;
        bubble       = 1'b0;
        adv          = 1'b1;
        redirect_acc = 1'b0;
        if (want_stall) begin
            // Whole pipe frozen; a redirect in EX will re-present once memory is ready.
            pc_we   = 1'b0;
            ifid_we = 1'b0;
            adv     = 1'b0;
        end else if (redirect) begin
            // Wrong-path fetch and decode are squashed, any pending load-use window is moot.
            ifid_fl      = 1'b1;
            bubble       = 1'b1;
            redirect_acc = 1'b1;
            if (FLUSH_CYCLES > 0) begin
                state_d = HZ_FLUSH;
                cnt_d   = FL_RELOAD;
            end else begin
                state_d = HZ_RUN;
                cnt_d   = '0;
            end
        end else begin
            case (state_q)
                HZ_LOAD_USE: begin
                    pc_we   = 1'b0;
                    ifid_we = 1'b0;
                    bubble  = 1'b1;
                    if (cnt_q == 4'd0) state_d = HZ_RUN;
                    else               cnt_d   = cnt_q - 4'd1;
                end
                HZ_FLUSH: begin
                    ifid_fl = 1'b1;
                    bubble  = 1'b1;
                    if (cnt_q == 4'd0) state_d = HZ_RUN;
                    else               cnt_d   = cnt_q - 4'd1;
                end
                default: begin
                    if (lu) begin
                        pc_we   = 1'b0;
                        ifid_we = 1'b0;
                        bubble  = 1'b1;
                        if (LOAD_USE_CYCLES > 1) begin
                            state_d = HZ_LOAD_USE;
                            cnt_d   = LU_RELOAD;
                        end else begin
                            state_d = HZ_RUN;
                        end
                    end
                end
            endcase
        end
    end

    // Memory wait watchdog: count consecutive stall cycles, latch the timeout once the limit is reached.
    always_comb begin
        wait_d        = '0;
        mem_timeout_d = mem_timeout_q;
        if (want_stall) begin
            wait_d = (wait_q == 16'hFFFF) ? wait_q : wait_q + 16'd1;
            if (wait_q >= TIMEOUT_LIM) mem_timeout_d = 1'b1;
        end
    end

    // Sequencer and watchdog state registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= HZ_RUN;
            cnt_q         <= '0;
            wait_q        <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            wait_q        <= wait_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    // While reset is held the pipe runs free regardless of hazard inputs.
    assign pc_write_enable    = reset ? pc_we   : 1'b1;
    assign if_id_write_enable = reset ? ifid_we : 1'b1;
    assign if_id_flush        = reset ? ifid_fl : 1'b0;
    assign id_ex_bubble       = reset ? bubble  : 1'b0;
    assign no_stall           = reset ? adv     : 1'b1;
    assign mem_timeout        = mem_timeout_q;

    perf_counter_sat #(.WIDTH(COUNTER_WIDTH)) u_stall_cnt (
        .clock   (clock),
        .reset   (reset),
        .inc_i   (~pc_we),
        .count_o (stall_count)
    );

    perf_counter_sat #(.WIDTH(COUNTER_WIDTH)) u_flush_cnt (
        .clock   (clock),
        .reset   (reset),
        .inc_i   (redirect_acc),
        .count_o (flush_count)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctl.sv
// Purpose: scoreboard bench for pipeline_hazard_ctl against a remaining-cycles reference model.
// Latency: expectations pushed at drive time, popped and compared on the following falling edge.
// Backpressure: n/a.
module tb_pipeline_hazard_ctl;

    localparam int LUC = 5;
    localparam int FLC = 2;
    localparam int MTO = 4;
    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          want_stall = 1'b0, redirect = 1'b0;
    logic [4:0]    id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic          id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0, ex_mem_read = 1'b0;
    logic          pc_write_enable, if_id_write_enable, if_id_flush, id_ex_bubble, no_stall;
    logic [CW-1:0] stall_count, flush_count;
    logic          mem_timeout;

    pipeline_hazard_ctl #(
        .LOAD_USE_CYCLES (LUC),
        .FLUSH_CYCLES    (FLC),
        .MEM_TIMEOUT     (MTO),
        .COUNTER_WIDTH   (CW)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .want_stall         (want_stall),
        .redirect           (redirect),
        .id_rs1             (id_rs1),
        .id_rs2             (id_rs2),
        .id_uses_rs1        (id_uses_rs1),
        .id_uses_rs2        (id_uses_rs2),
        .ex_rd              (ex_rd),
        .ex_mem_read        (ex_mem_read),
        .pc_write_enable    (pc_write_enable),
        .if_id_write_enable (if_id_write_enable),
        .if_id_flush        (if_id_flush),
        .id_ex_bubble       (id_ex_bubble),
        .no_stall           (no_stall),
        .stall_count        (stall_count),
        .flush_count        (flush_count),
        .mem_timeout        (mem_timeout)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic          pc_we;
        logic          ifid_we;
        logic          ifid_fl;
        logic          bub;
        logic          ns;
        logic          to;
        logic [CW-1:0] sc;
        logic [CW-1:0] fc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: remaining bubble / flush cycles as plain integers.
    int m_lu_left, m_fl_left, m_sc, m_fc, m_wait;
    bit m_to;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_lu_left = 0; m_fl_left = 0; m_sc = 0; m_fc = 0; m_wait = 0; m_to = 0;
    endtask

    // One clock of stimulus; the expected response is queued for the monitor.
    task automatic step(input logic ws, input logic rd, input logic [4:0] r1, input logic [4:0] r2,
                        input logic u1, input logic u2, input logic [4:0] erd, input logic emr);
        exp_t e;
        bit   lu;
        @(posedge clock); #1;
        want_stall = ws; redirect = rd; id_rs1 = r1; id_rs2 = r2;
        id_uses_rs1 = u1; id_uses_rs2 = u2; ex_rd = erd; ex_mem_read = emr;
        lu = emr && (erd != 0) && ((u1 && r1 == erd) || (u2 && r2 == erd));
        e.sc = CW'(m_sc); e.fc = CW'(m_fc); e.to = m_to;
        e.pc_we = 1; e.ifid_we = 1; e.ifid_fl = 0; e.bub = 0; e.ns = 1;
        if (ws) begin
            e.pc_we = 0; e.ifid_we = 0; e.ns = 0;
        end else if (rd) begin
            e.ifid_fl = 1; e.bub = 1;
            m_fc = (m_fc < SAT) ? m_fc + 1 : SAT;
            m_lu_left = 0; m_fl_left = FLC;
        end else if (m_lu_left > 0) begin
            e.pc_we = 0; e.ifid_we = 0; e.bub = 1;
            m_lu_left--;
        end else if (m_fl_left > 0) begin
            e.ifid_fl = 1; e.bub = 1;
            m_fl_left--;
        end else if (lu) begin
            e.pc_we = 0; e.ifid_we = 0; e.bub = 1;
            m_lu_left = LUC - 1;
        end
        if (!e.pc_we) m_sc = (m_sc < SAT) ? m_sc + 1 : SAT;
        if (ws && m_wait >= MTO) m_to = 1;
        m_wait = ws ? m_wait + 1 : 0;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(posedge clock); #1;
        reset = 0;
        want_stall = 0; redirect = 0; ex_mem_read = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        model_reset();
        repeat (2) @(posedge clock);
        #1 reset = 1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " pc_write_enable"}, 32'(pc_write_enable), 32'd1);
        check({tag, " if_id_write_enable"}, 32'(if_id_write_enable), 32'd1);
        check({tag, " no_stall"}, 32'(no_stall), 32'd1);
        check({tag, " if_id_flush"}, 32'(if_id_flush), 32'd0);
        check({tag, " id_ex_bubble"}, 32'(id_ex_bubble), 32'd0);
        check({tag, " stall_count"}, 32'(stall_count), 32'd0);
        check({tag, " flush_count"}, 32'(flush_count), 32'd0);
        check({tag, " mem_timeout"}, 32'(mem_timeout), 32'd0);
    endtask

    // Monitor: every falling edge with a pending expectation compares the DUT outputs.
    initial begin
        forever begin
            exp_t e;
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pc_write_enable", 32'(pc_write_enable), 32'(e.pc_we));
                check("if_id_write_enable", 32'(if_id_write_enable), 32'(e.ifid_we));
                check("if_id_flush", 32'(if_id_flush), 32'(e.ifid_fl));
                check("id_ex_bubble", 32'(id_ex_bubble), 32'(e.bub));
                check("no_stall", 32'(no_stall), 32'(e.ns));
                check("stall_count", 32'(stall_count), 32'(e.sc));
                check("flush_count", 32'(flush_count), 32'(e.fc));
                check("mem_timeout", 32'(mem_timeout), 32'(e.to));
            end
        end
    end

    initial begin
        int ws_left;
        model_reset();
        // Reset held with a stall request present: outputs must still read as free-running.
        want_stall = 1;
        #1 check_reset_outputs("por");
        want_stall = 0;
        repeat (2) @(posedge clock);
        #1 reset = 1;

        // Load-use on rs1 (LUC bubbles), then x0 load which must not hazard.
        step(0, 0, 5, 0, 1, 0, 5, 1);
        idle(6);
        step(0, 0, 0, 0, 1, 1, 0, 1);
        step(0, 0, 3, 7, 0, 1, 7, 1);
        idle(6);
        // Redirect coinciding with a load-use: flush window only.
        step(0, 1, 5, 0, 1, 0, 5, 1);
        idle(4);
        // Stall in the middle of a flush window, then redirect during a load-use window.
        step(0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, 0);
        idle(4);
        step(0, 0, 9, 0, 1, 0, 9, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        idle(4);
        do_reset();

        // Watchdog: 6 consecutive stall cycles trip the sticky timeout.
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0, 0, 0, 0);
        idle(3);
        // Long stall saturates the stall counter.
        for (int i = 0; i < 20; i++) step(1, 1, 0, 0, 0, 0, 0, 0);
        idle(2);
        do_reset();

        // Asynchronous reset inside a load-use window (first stall cycle after entry).
        step(0, 0, 4, 0, 1, 0, 4, 1);
        @(posedge clock); #1;
        check("lu window pc_write_enable", 32'(pc_write_enable), 32'd0);
        #2 reset = 0;
        #1 check_reset_outputs("async");
        model_reset();
        repeat (2) @(posedge clock);
        #1 reset = 1;
        want_stall = 0; redirect = 0; ex_mem_read = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        idle(2);

        // Randomized segments, each closed with a reset.
        for (int seg = 0; seg < 4; seg++) begin
            ws_left = 0;
            for (int i = 0; i < 150; i++) begin
                logic ws;
                ws = 0;
                if (ws_left > 0) begin
                    ws = 1; ws_left--;
                end else if ($urandom_range(0, 9) == 0) begin
                    ws_left = $urandom_range(1, 8);
                end
                step(ws, ($urandom_range(0, 7) == 0),
                     5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            end
            do_reset();
        end

        repeat (3) @(negedge clock);
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL scoreboard drain: %0d left, expected 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
